isif_frame_ctrl: RTL and testbench
==================================

Name: isif_frame_ctrl

Overview:
- Frame sequencer that sits between the input-stream FIFO interface (isif_* side) and the Sobel line-buffer writer.
- Drains the FIFO and locates frame and line boundaries from TUSER (start of frame, SOF) and TLAST (end of line, EOL).
- Emits one registered pixel word per beat, tagged with column, row and line-buffer select.
- Detects malformed frames and resynchronises without stalling the stream.

Parameters:
- TBITS, 32, data word width (one pixel word per beat).
- COL_BITS, 11, width of the column counter and cfg_width.
- ROW_BITS, 11, width of the row counter and cfg_height.
- NUM_LBUF, 3, number of rotating line buffers downstream (2..4).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset, synchronous, active-high.
- cfg_enable  in  1  run enable; sampled only in IDLE and at frame end.
- cfg_width  in  COL_BITS  pixels per line; latched on SOF acceptance; must be >= 1.
- cfg_height  in  ROW_BITS  lines per frame; latched on SOF acceptance; must be >= 1.
- isif_data_dout  in  TBITS  FIFO head data, first-word-fall-through.
- isif_last_dout  in  1  FIFO head EOL flag.
- isif_user_dout  in  1  FIFO head SOF flag.
- isif_empty_n  in  1  FIFO head valid.
- isif_read  out  1  pop FIFO head this cycle.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accepts pixel.
- pix_data  out  TBITS  pixel word.
- pix_col  out  COL_BITS  column of pix_data.
- pix_row  out  ROW_BITS  row of pix_data.
- pix_lbuf  out  2  target line buffer index, 0..NUM_LBUF-1.
- pix_eol  out  1  pix_data is the last pixel of its line.
- frame_done  out  1  one-cycle pulse when the final pixel of a frame is handed off.
- busy  out  1  state != IDLE.
- err_flags  out  3  sticky: [0] early EOL, [1] late/missing EOL, [2] unexpected SOF; cleared only by ARESET.

Behaviour:
- Reset: state=IDLE. All outputs 0: isif_read, pix_valid, pix_data, pix_col, pix_row, pix_lbuf, pix_eol, frame_done, busy, err_flags. Internal counters 0.
- Beat definition: a beat is consumed when isif_read & isif_empty_n. isif_read is combinational and never asserted while isif_empty_n=0.
- Output register: single stage; pixel appears on pix_* the cycle after consumption (latency 1).
  - pix_* hold stable while pix_valid & ~pix_ready.
  - Pixel-forwarding states: isif_read = isif_empty_n & (~pix_valid | pix_ready).
  - Discard states: isif_read = isif_empty_n.
- IDLE: isif_read=0. Moves to WAIT_SOF when cfg_enable=1.
- WAIT_SOF:
  - Discards beats with user=0.
  - A beat with user=1 latches cfg_width and cfg_height, is forwarded as col=0, row=0, lbuf=0, and the state moves to ACTIVE.
  - If cfg_width=1 that beat is also the line end: apply the ACTIVE line-end rules.
- ACTIVE: each consumed beat is forwarded; col increments per beat.
  - Normal line end (last=1 and col=W-1): pix_eol=1; col->0, row+1, lbuf rotates modulo NUM_LBUF.
  - Early EOL (last=1, col<W-1): set err[0], pix_eol=1, then take the normal line end.
  - Late EOL (col=W-1, last=0): set err[1], forward the beat with pix_eol=1, go to DISCARD_LINE.
  - Unexpected SOF (user=1 with col!=0 or row!=0): set err[2], restart the frame. This beat is forwarded as col=0, row=0, lbuf=0 and cfg is re-latched.
  - Frame end (line end on row=H-1): frame_done pulses the cycle that final pixel completes its handshake (pix_valid & pix_ready). Next state is WAIT_SOF if cfg_enable=1, else IDLE.
  - Simultaneous cases: early EOL plus unexpected SOF records both errors and applies the SOF restart. If backpressure holds the final pixel, frame_done waits for the handshake.
- DISCARD_LINE:
  - Discards beats until one with last=1, which is also discarded. Then row+1, lbuf rotates, col=0, and the frame-end check is applied.
  - A user=1 beat here sets err[2] and is handled exactly as the WAIT_SOF acceptance.
- cfg_enable deasserted mid-frame: the frame completes and the state then returns to IDLE.
- ARESET mid-frame: returns to reset values immediately; FIFO contents are untouched.

Optional Feature:
- FRAME_STATS_EN
- Defined:
  - Adds outputs frame_cnt[15:0], which increments on each frame_done and wraps at 0xFFFF->0.
  - Adds drop_cnt[15:0], which counts beats discarded in WAIT_SOF or DISCARD_LINE and saturates at 0xFFFF.
  - Both reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Clean frame: cfg 4x3, 12 beats with SOF on beat 0 and EOL every 4th, pix_ready=1 -> 12 pixels with col 0..3, rows 0..2, lbuf 0,1,2. frame_done pulses one cycle after beat 12 is consumed. err_flags=0.
- Leading garbage: 5 beats with user=0, then the 4x3 frame -> 5 beats discarded with no pix_valid, then the frame as above. With FRAME_STATS_EN: drop_cnt=5, frame_cnt=1.
- Early/late EOL: 4x2 frame where row 0 has EOL on col 2 and row 1 lacks EOL at col 3, followed by 2 extra beats with EOL on the second -> err_flags=3'b011. Row 1 emits 4 pixels and the 2 extras are dropped. frame_done pulses.
- Mid-frame SOF: user=1 at row 1 col 2 -> err[2]=1, that pixel emitted as col 0, row 0, lbuf 0, and the following frame completes normally.
- Backpressure: pix_ready toggles 1,0,0,1 with the FIFO continuously non-empty -> pix_* stable while stalled, no beats lost or duplicated, isif_read=0 during stall cycles.
- Disable and reset: clear cfg_enable mid-frame -> frame completes, busy=0, isif_read stays 0. Assert ARESET mid-line -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/isif_frame_ctrl.sv
// -----------------------------------------------------------------------------
// isif_frame_ctrl
//
// Frame sequencer between the input-stream FIFO (first-word-fall-through) and
// the Sobel line-buffer writer. It drains the FIFO and finds frame starts
// (TUSER = SOF) and line ends (TLAST = EOL). Each pixel word is emitted from a
// single output register and tagged with column, row and line-buffer index.
// Malformed frames are flagged in sticky error bits. The block then
// resynchronises without stalling the stream.
//
// Optional feature: define FRAME_STATS_EN to add the frame_cnt and drop_cnt
// statistics outputs.
//
// Ports
//   ACLK, ARESET          clock; synchronous active-high reset
//   cfg_enable            run enable (sampled in IDLE and at frame end)
//   cfg_width/height      frame geometry, latched when an SOF beat is accepted
//   isif_*_dout           FIFO head data / EOL / SOF
//   isif_empty_n          FIFO head valid
//   isif_read             pop FIFO head this cycle (combinational)
//   pix_valid/ready       output handshake
//   pix_data/col/row      pixel word and its position
//   pix_lbuf              rotating line-buffer select, 0..NUM_LBUF-1
//   pix_eol               pixel closes its line
//   frame_done            pulse as the final pixel of a frame is handed off
//   busy                  state != IDLE
//   err_flags             sticky {unexpected SOF, late EOL, early EOL}
//   frame_cnt, drop_cnt   (FRAME_STATS_EN only) frames done / beats discarded
// -----------------------------------------------------------------------------
module isif_frame_ctrl #(
  parameter int TBITS    = 32,
  parameter int COL_BITS = 11,
  parameter int ROW_BITS = 11,
  parameter int NUM_LBUF = 3
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cfg_enable,
  input  logic [COL_BITS-1:0] cfg_width,
  input  logic [ROW_BITS-1:0] cfg_height,
  input  logic [TBITS-1:0]    isif_data_dout,
  input  logic                isif_last_dout,
  input  logic                isif_user_dout,
  input  logic                isif_empty_n,
  output logic                isif_read,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [TBITS-1:0]    pix_data,
  output logic [COL_BITS-1:0] pix_col,
  output logic [ROW_BITS-1:0] pix_row,
  output logic [1:0]          pix_lbuf,
  output logic                pix_eol,
  output logic                frame_done,
  output logic                busy,
`ifdef FRAME_STATS_EN
  output logic [15:0]         frame_cnt,
  output logic [15:0]         drop_cnt,
`endif
  output logic [2:0]          err_flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_ACTIVE,
    S_DISCARD
  } state_t;

  state_t              r_state;
  logic [COL_BITS-1:0] r_col, r_width;
  logic [ROW_BITS-1:0] r_row, r_height;
  logic [1:0]          r_lbuf;
  logic [2:0]          r_err;
  logic                r_pix_valid, r_pix_eol, r_pix_final, r_disc_done;
  logic [TBITS-1:0]    r_pix_data;
  logic [COL_BITS-1:0] r_pix_col;
  logic [ROW_BITS-1:0] r_pix_row;
  logic [1:0]          r_pix_lbuf;

  logic       w_slot_free, w_beat, w_sof_take;
  logic       w_last_col, w_last_row, w_sof_line_end, w_sof_frame_end;
  logic [1:0] w_lbuf_next;
  state_t     w_end_state;

  // The output register can take a new pixel when it is empty or draining.
  assign w_slot_free = ~r_pix_valid | pix_ready;

  // WAIT_SOF and DISCARD drop non-SOF beats freely. An SOF beat in those
  // states is forwarded, so it must wait for the output slot like ACTIVE.
  always_comb begin
    // NOTE: default first so every path assigns isif_read and no latch is inferred.
    isif_read = 1'b0;
    if (!ARESET) begin
      case (r_state)
        S_WAIT_SOF, S_DISCARD: isif_read = isif_empty_n & (~isif_user_dout | w_slot_free);
        S_ACTIVE:              isif_read = isif_empty_n & w_slot_free;
        default:               isif_read = 1'b0;
      endcase
    end
  end

  assign w_beat = isif_read & isif_empty_n;

  // SOF restarts the frame, except at (0,0) in ACTIVE. That position
  // cannot occur after a legitimate SOF has been taken.
  assign w_sof_take = w_beat & isif_user_dout &
                      ((r_state != S_ACTIVE) | (r_col != '0) | (r_row != '0));

  assign w_last_col      = (r_col == r_width - COL_BITS'(1));
  assign w_last_row      = (r_row == r_height - ROW_BITS'(1));
  assign w_lbuf_next     = (r_lbuf == 2'(NUM_LBUF - 1)) ? 2'd0 : r_lbuf + 2'd1;
  assign w_end_state     = cfg_enable ? S_WAIT_SOF : S_IDLE;
  // Geometry of the frame an SOF beat would open, read from the live cfg.
  assign w_sof_line_end  = (cfg_width == COL_BITS'(1));
  assign w_sof_frame_end = w_sof_line_end & (cfg_height == ROW_BITS'(1));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_lbuf      <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_err       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_pix_col   <= '0;
      r_pix_row   <= '0;
      r_pix_lbuf  <= '0;
      r_pix_eol   <= 1'b0;
      r_pix_final <= 1'b0;
      r_disc_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; later assignments in this block override earlier defaults.
      r_disc_done <= 1'b0;
      if (r_state == S_IDLE && cfg_enable) r_state <= S_WAIT_SOF;
      if (pix_ready) r_pix_valid <= 1'b0;

      if (w_sof_take) begin
        if (r_state != S_WAIT_SOF) r_err[2] <= 1'b1;
        if (r_state == S_ACTIVE && isif_last_dout && !w_last_col) r_err[0] <= 1'b1;
        r_width     <= cfg_width;
        r_height    <= cfg_height;
        r_pix_valid <= 1'b1;
        r_pix_data  <= isif_data_dout;
        r_pix_col   <= '0;
        r_pix_row   <= '0;
        r_pix_lbuf  <= '0;
        r_pix_eol   <= w_sof_line_end;
        r_pix_final <= w_sof_frame_end;
        if (w_sof_frame_end) begin
          r_state <= w_end_state;
          r_col   <= '0;
          r_row   <= '0;
          r_lbuf  <= '0;
        end else if (w_sof_line_end) begin
          r_state <= S_ACTIVE;
          r_col   <= '0;
          r_row   <= ROW_BITS'(1);
          r_lbuf  <= 2'd1;
        end else begin
          r_state <= S_ACTIVE;
          r_col   <= COL_BITS'(1);
          r_row   <= '0;
          r_lbuf  <= '0;
        end
      end else if (w_beat && r_state == S_ACTIVE) begin
        r_pix_valid <= 1'b1;
        r_pix_data  <= isif_data_dout;
        r_pix_col   <= r_col;
        r_pix_row   <= r_row;
        r_pix_lbuf  <= r_lbuf;
        // A missing EOL still closes the line on the output side.
        r_pix_eol   <= isif_last_dout | w_last_col;
        r_pix_final <= isif_last_dout & w_last_row;
        if (isif_last_dout) begin
          if (!w_last_col) r_err[0] <= 1'b1;
          r_col <= '0;
          if (w_last_row) begin
            r_state <= w_end_state;
            r_row   <= '0;
            r_lbuf  <= '0;
          end else begin
            r_row  <= r_row + ROW_BITS'(1);
            r_lbuf <= w_lbuf_next;
          end
        end else if (w_last_col) begin
          r_err[1] <= 1'b1;
          r_state  <= S_DISCARD;
        end else begin
          r_col <= r_col + COL_BITS'(1);
        end
      end else if (w_beat && r_state == S_DISCARD && isif_last_dout) begin
        r_col <= '0;
        if (w_last_row) begin
          // The frame's last forwarded pixel is already gone, so flag the end here.
          r_state     <= w_end_state;
          r_row       <= '0;
          r_lbuf      <= '0;
          r_disc_done <= 1'b1;
        end else begin
          r_state <= S_ACTIVE;
          r_row   <= r_row + ROW_BITS'(1);
          r_lbuf  <= w_lbuf_next;
        end
      end
    end
  end

  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_col    = r_pix_col;
  assign pix_row    = r_pix_row;
  assign pix_lbuf   = r_pix_lbuf;
  assign pix_eol    = r_pix_eol;
  assign err_flags  = r_err;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_pix_valid & pix_ready & r_pix_final) | r_disc_done;

`ifdef FRAME_STATS_EN
  logic [15:0] r_frame_cnt, r_drop_cnt;
  logic        w_drop;

  assign w_drop = w_beat & ~isif_user_dout &
                  ((r_state == S_WAIT_SOF) | (r_state == S_DISCARD));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_isif_frame_ctrl.sv
`timescale 1ns/1ps
module tb_isif_frame_ctrl;
  localparam int TBITS    = 32;
  localparam int COL_BITS = 11;
  localparam int ROW_BITS = 11;
  localparam int NUM_LBUF = 3;

  logic                ACLK = 1'b0;
  logic                ARESET = 1'b1;
  logic                cfg_enable = 1'b0;
  logic [COL_BITS-1:0] cfg_width = '0;
  logic [ROW_BITS-1:0] cfg_height = '0;
  logic [TBITS-1:0]    isif_data_dout = '0;
  logic                isif_last_dout = 1'b0;
  logic                isif_user_dout = 1'b0;
  logic                isif_empty_n = 1'b0;
  logic                isif_read;
  logic                pix_valid;
  logic                pix_ready = 1'b0;
  logic [TBITS-1:0]    pix_data;
  logic [COL_BITS-1:0] pix_col;
  logic [ROW_BITS-1:0] pix_row;
  logic [1:0]          pix_lbuf;
  logic                pix_eol;
  logic                frame_done;
  logic                busy;
  logic [2:0]          err_flags;
`ifdef FRAME_STATS_EN
  logic [15:0]         frame_cnt;
  logic [15:0]         drop_cnt;
`endif

  isif_frame_ctrl #(
    .TBITS(TBITS), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .NUM_LBUF(NUM_LBUF)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_enable(cfg_enable),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .isif_data_dout(isif_data_dout), .isif_last_dout(isif_last_dout),
    .isif_user_dout(isif_user_dout), .isif_empty_n(isif_empty_n),
    .isif_read(isif_read), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_col(pix_col), .pix_row(pix_row),
    .pix_lbuf(pix_lbuf), .pix_eol(pix_eol), .frame_done(frame_done),
    .busy(busy),
`ifdef FRAME_STATS_EN
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
`endif
    .err_flags(err_flags)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [TBITS-1:0] data;
    logic             last;
    logic             user;
  } beat_t;

  typedef struct {
    logic [TBITS-1:0]    data;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic [1:0]          lbuf;
    logic                eol;
    logic                fin;
  } pix_t;

  beat_t fifo_q[$];
  pix_t  exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (beat-level, in stream order) ----------
  // mode: 0 waiting for SOF, 1 inside a line, 2 dropping rest of a long line
  int         m_mode, m_col, m_row, m_lb, m_w, m_h, m_frames, m_drops;
  logic [2:0] m_err;

  task automatic model_reset();
    m_mode = 0; m_col = 0; m_row = 0; m_lb = 0; m_w = 1; m_h = 1;
    m_frames = 0; m_drops = 0; m_err = '0;
  endtask

  task automatic model_line_end();
    m_col = 0;
    if (m_row == m_h - 1) begin
      m_frames++;
      m_mode = 0; m_row = 0; m_lb = 0;
    end else begin
      m_row++;
      m_lb   = (m_lb + 1) % NUM_LBUF;
      m_mode = 1;
    end
  endtask

  task automatic model_emit(input beat_t b, input int c, input int r, input int l,
                            input bit eol, input bit fin);
    pix_t p;
    p.data = b.data; p.col = COL_BITS'(c); p.row = ROW_BITS'(r);
    p.lbuf = 2'(l); p.eol = eol; p.fin = fin;
    exp_q.push_back(p);
  endtask

  task automatic model_beat(input beat_t b);
    if (b.user && (m_mode != 1 || m_col != 0 || m_row != 0)) begin
      if (m_mode != 0) m_err[2] = 1'b1;
      if (m_mode == 1 && b.last && m_col < m_w - 1) m_err[0] = 1'b1;
      m_w = int'(cfg_width); m_h = int'(cfg_height);
      model_emit(b, 0, 0, 0, m_w == 1, m_w == 1 && m_h == 1);
      m_mode = 1; m_col = 0; m_row = 0; m_lb = 0;
      if (m_w == 1) model_line_end();
      else m_col = 1;
    end else if (m_mode == 1) begin
      if (b.last) begin
        if (m_col < m_w - 1) m_err[0] = 1'b1;
        model_emit(b, m_col, m_row, m_lb, 1'b1, m_row == m_h - 1);
        model_line_end();
      end else if (m_col == m_w - 1) begin
        m_err[1] = 1'b1;
        model_emit(b, m_col, m_row, m_lb, 1'b1, 1'b0);
        m_mode = 2;
      end else begin
        model_emit(b, m_col, m_row, m_lb, 1'b0, 1'b0);
        m_col++;
      end
    end else begin
      if (m_drops < 65535) m_drops++;
      if (m_mode == 2 && b.last) model_line_end();
    end
  endtask

  task automatic push(input logic [TBITS-1:0] d, input bit last, input bit user);
    beat_t b;
    b.data = d; b.last = last; b.user = user;
    fifo_q.push_back(b);
    model_beat(b);
  endtask

  task automatic push_raw(input logic [TBITS-1:0] d, input bit last, input bit user);
    beat_t b;
    b.data = d; b.last = last; b.user = user;
    fifo_q.push_back(b);
  endtask

  task automatic push_frame(input int w, input int h, input bit corrupt);
    bit last, user;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        user = (r == 0 && c == 0);
        last = (c == w - 1);
        if (corrupt) begin
          if ($urandom_range(0, 15) == 0) last = ~last;
          if ($urandom_range(0, 29) == 0) user = 1'b1;
        end
        push($urandom, last, user);
      end
    end
  endtask

  // ---------------- FIFO driver and output monitor -------------------------
  bit          pop_pend = 1'b0;
  bit          prev_stall = 1'b0;
  bit          chk_stall_rd = 1'b0;
  logic [57:0] snap = '0;
  int          done_cnt = 0;

  task automatic tick(input bit rdy, input bit gate);
    pix_t        e;
    logic [57:0] now;
    @(negedge ACLK);
    if (pop_pend) fifo_q.delete(0);
    pix_ready = rdy;
    if (gate && fifo_q.size() > 0) begin
      isif_empty_n   = 1'b1;
      isif_data_dout = fifo_q[0].data;
      isif_last_dout = fifo_q[0].last;
      isif_user_dout = fifo_q[0].user;
    end else begin
      isif_empty_n   = 1'b0;
      isif_data_dout = $urandom;
      isif_last_dout = 1'($urandom_range(0, 1));
      isif_user_dout = 1'($urandom_range(0, 1));
    end
    #1;
    pop_pend = isif_read && isif_empty_n;
    if (!isif_empty_n) check("read_while_empty", 64'(isif_read), 64'(0));
    now = {pix_valid, pix_data, pix_col, pix_row, pix_lbuf, pix_eol};
    if (prev_stall) check("stall_hold", 64'(now), 64'(snap));
    if (chk_stall_rd && pix_valid && !pix_ready) check("stall_read", 64'(isif_read), 64'(0));
    prev_stall = pix_valid && !pix_ready;
    snap = now;
    if (frame_done) done_cnt++;
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 64'(pix_data), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("pixel", 64'({pix_data, pix_col, pix_row, pix_lbuf, pix_eol}),
              64'({e.data, e.col, e.row, e.lbuf, e.eol}));
        if (e.fin) check("frame_done_hs", 64'(frame_done), 64'(1));
      end
    end
  endtask

  task automatic drain(input int rdy_pct, input int gate_pct);
    int n = 0;
    while ((fifo_q.size() > 0 || pix_valid || pop_pend) && n < 4000) begin
      tick($urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < gate_pct);
      n++;
    end
    check("drain_timeout", 64'(n >= 4000), 64'(0));
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
  endtask

  task automatic seg_check();
    check("exp_left", 64'(exp_q.size()), 64'(0));
    check("frames", 64'(done_cnt), 64'(m_frames));
    check("err_flags", 64'(err_flags), 64'(m_err));
`ifdef FRAME_STATS_EN
    check("frame_cnt", 64'(frame_cnt), 64'(m_frames & 16'hFFFF));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0);
    ARESET = 1'b1;
    prev_stall = 1'b0;
    tick(1'b0, 1'b0);
    check("rst_isif_read", 64'(isif_read), 64'(0));
    check("rst_pix_valid", 64'(pix_valid), 64'(0));
    check("rst_pix_data", 64'(pix_data), 64'(0));
    check("rst_pix_col", 64'(pix_col), 64'(0));
    check("rst_pix_row", 64'(pix_row), 64'(0));
    check("rst_pix_lbuf", 64'(pix_lbuf), 64'(0));
    check("rst_pix_eol", 64'(pix_eol), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err_flags", 64'(err_flags), 64'(0));
`ifdef FRAME_STATS_EN
    check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
`endif
    ARESET = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    model_reset();
    done_cnt = 0;
    pop_pend = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rdy_pat [4];
    int n;
    int w, h;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    model_reset();
    cfg_enable = 1'b1;
    cfg_width  = 11'd4;
    cfg_height = 11'd3;
    do_reset();

    // Clean 4x3 frame.
    push_frame(4, 3, 1'b0);
    drain(100, 100);
    check("clean_err", 64'(err_flags), 64'(0));
    check("clean_frames", 64'(done_cnt), 64'(1));
    seg_check();

    // Leading garbage, then a clean frame.
    do_reset();
    for (int i = 0; i < 5; i++) push($urandom, 1'($urandom_range(0, 1)), 1'b0);
    push_frame(4, 3, 1'b0);
    drain(100, 100);
    check("garbage_frames", 64'(done_cnt), 64'(1));
`ifdef FRAME_STATS_EN
    check("garbage_drop_cnt", 64'(drop_cnt), 64'(5));
    check("garbage_frame_cnt", 64'(frame_cnt), 64'(1));
`endif
    seg_check();

    // Early EOL in row 0, missing EOL in row 1, two extra beats.
    do_reset();
    cfg_width  = 11'd4;
    cfg_height = 11'd2;
    push($urandom, 1'b0, 1'b1);
    push($urandom, 1'b0, 1'b0);
    push($urandom, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push($urandom, 1'b0, 1'b0);
    push($urandom, 1'b0, 1'b0);
    push($urandom, 1'b1, 1'b0);
    drain(100, 100);
    check("eol_err", 64'(err_flags), 64'(3'b011));
    check("eol_frames", 64'(done_cnt), 64'(1));
    seg_check();

    // SOF arriving at row 1, col 2 restarts the frame.
    do_reset();
    cfg_width  = 11'd4;
    cfg_height = 11'd3;
    for (int i = 0; i < 4; i++) push($urandom, i == 3, i == 0);
    push($urandom, 1'b0, 1'b0);
    push($urandom, 1'b0, 1'b0);
    push_frame(4, 3, 1'b0);
    drain(100, 100);
    check("sof_err", 64'(err_flags), 64'(3'b100));
    check("sof_frames", 64'(done_cnt), 64'(1));
    seg_check();

    // Backpressure pattern 1,0,0,1 with the FIFO kept full.
    do_reset();
    push_frame(4, 3, 1'b0);
    push_frame(4, 3, 1'b0);
    chk_stall_rd = 1'b1;
    n = 0;
    while ((fifo_q.size() > 0 || pix_valid || pop_pend) && n < 500) begin
      tick(rdy_pat[n % 4], 1'b1);
      n++;
    end
    chk_stall_rd = 1'b0;
    check("bp_timeout", 64'(n >= 500), 64'(0));
    tick(1'b1, 1'b1);
    check("bp_frames", 64'(done_cnt), 64'(2));
    seg_check();

    // Disable mid-frame: the frame completes, then the block idles.
    do_reset();
    push_frame(4, 3, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    cfg_enable = 1'b0;
    drain(100, 100);
    check("dis_busy", 64'(busy), 64'(0));
    check("dis_frames", 64'(done_cnt), 64'(1));
    seg_check();
    push_raw($urandom, 1'b0, 1'b1);
    push_raw($urandom, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1);
      check("dis_read", 64'(isif_read), 64'(0));
    end
    cfg_enable = 1'b1;

    // Reset in the middle of a line.
    do_reset();
    push_frame(4, 3, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    do_reset();

    // Randomised geometry, corruption, gaps and backpressure.
    for (int seg = 0; seg < 14; seg++) begin
      if (seg % 5 == 0) do_reset();
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 4);
      cfg_width  = 11'(w);
      cfg_height = 11'(h);
      for (int f = 0; f < 4; f++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          push($urandom, 1'($urandom_range(0, 1)), 1'b0);
        push_frame(w, h, seg > 1);
      end
      drain(70, 75);
      seg_check();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
